// File: rtl/xadc_smp_pkg.sv
// Shared definitions for the XADC sample buffer: slot register map, CTRL layout, channel codes.
package xadc_smp_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_POP     = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_HEAD    = 2'd1;
    localparam logic [1:0] REG_CTRL_RB = 2'd2;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLR_BIT   = 1;
    localparam int CTRL_CHSEL_LSB = 4;
    localparam int CTRL_CHSEL_MSB = 8;
    localparam int CTRL_DEC_LSB   = 16;
    localparam int CTRL_DEC_MSB   = 31;

    localparam logic [4:0] CH_AUX3   = 5'b10011;
    localparam logic [4:0] CH_AUX10  = 5'b11010;
    localparam logic [4:0] CH_AUX2   = 5'b10010;
    localparam logic [4:0] CH_AUX11  = 5'b11011;
    localparam logic [4:0] CH_TEMP   = 5'b00000;
    localparam logic [4:0] CH_VCCINT = 5'b00001;

    typedef struct packed {
        logic [15:0] dec;
        logic [4:0]  chsel;
        logic        en;
    } ctrl_t;

    // The clear bit is a write-only pulse, so it always reads back as 0.
    function automatic logic [31:0] ctrl_readback(input ctrl_t c);
        return {c.dec, 7'b0, c.chsel, 3'b0, c.en};
    endfunction

endpackage

// File: rtl/xadc_smp_fifo.sv
// First-word-fall-through FIFO on distributed RAM with wrap-around pointers and an explicit count.
module xadc_smp_fifo #(
    parameter int DEPTH_LOG2 = 9,
    parameter int W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [W-1:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & (~full | do_pop) & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/xadc_sample_buffer_core.sv
// Captures decimated samples of one XADC channel from the DRP stream into a FIFO read over the slot bus.
// Optional macro XADC_SMP_TSTAMP_EN stores a 16-bit push timestamp alongside each sample.
module xadc_sample_buffer_core
    import xadc_smp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int SMP_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [4:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    input  logic              smp_valid,
    input  logic [4:0]        smp_channel,
    input  logic [SMP_W-1:0]  smp_data,
    output logic              irq
);
    localparam logic [DEPTH_LOG2:0] HALF_CNT = (DEPTH_LOG2 + 1)'(1 << (DEPTH_LOG2 - 1));

`ifdef XADC_SMP_TSTAMP_EN
    localparam int FIFO_W = SMP_W + 16;
`else
    localparam int FIFO_W = SMP_W;
`endif

    ctrl_t               ctrl_q, ctrl_d, ctrl_new;
    logic [15:0]         dcnt_q, dcnt_d;
    logic                ovf_q, ovf_d;
    logic                wr_ctrl, wr_pop, clr, match, push;
    logic [FIFO_W-1:0]   fifo_din, fifo_dout;
    logic                fifo_empty, fifo_full;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [31:0]         head_word;
    logic                unused_bits;

    assign wr_ctrl = cs & write & (addr[1:0] == REG_CTRL);
    assign wr_pop  = cs & write & (addr[1:0] == REG_POP);
    assign clr     = wr_ctrl & wr_data[CTRL_CLR_BIT];

    assign ctrl_new.en    = wr_data[CTRL_EN_BIT];
    assign ctrl_new.chsel = wr_data[CTRL_CHSEL_MSB:CTRL_CHSEL_LSB];
    assign ctrl_new.dec   = wr_data[CTRL_DEC_MSB:CTRL_DEC_LSB];

    assign match = ctrl_q.en & smp_valid & (smp_channel == ctrl_q.chsel);
    assign push  = match & (dcnt_q == ctrl_q.dec);

    always_comb begin
        ctrl_d = ctrl_q;
        dcnt_d = dcnt_q;
        ovf_d  = ovf_q;
        if (wr_ctrl) ctrl_d = ctrl_new;
        if (match) dcnt_d = push ? 16'd0 : dcnt_q + 16'd1;
        // Retargeting the channel or ratio restarts the decimation phase.
        if (wr_ctrl && (ctrl_new.chsel != ctrl_q.chsel || ctrl_new.dec != ctrl_q.dec)) dcnt_d = '0;
        if (push && fifo_full && !wr_pop) ovf_d = 1'b1;
        if (clr) begin
            dcnt_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            dcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            dcnt_q <= dcnt_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef XADC_SMP_TSTAMP_EN
    logic [15:0] tstamp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tstamp_q <= '0;
        else       tstamp_q <= tstamp_q + 16'd1;
    end

    assign fifo_din  = {tstamp_q, smp_data};
    assign head_word = {fifo_dout[FIFO_W-1 -: 16], 16'(fifo_dout[SMP_W-1:0])};
`else
    assign fifo_din  = smp_data;
    assign head_word = 32'(fifo_dout);
`endif

    xadc_smp_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (wr_pop),
        .clr   (clr),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign irq = ctrl_q.en & (fifo_count >= HALF_CNT);

    always_comb begin
        rd_data = 32'h0;
        case (addr[1:0])
            REG_STATUS:  rd_data = {16'(fifo_count), 13'b0, ovf_q, fifo_full, fifo_empty};
            REG_HEAD:    rd_data = head_word;
            REG_CTRL_RB: rd_data = ctrl_readback(ctrl_q);
            default:     rd_data = 32'h0;
        endcase
    end

    assign unused_bits = &{1'b0, read, addr[4:2], wr_data[15:9], wr_data[3:2]};

endmodule

// File: tb/tb_xadc_sample_buffer_core.sv
// Self-checking bench for xadc_sample_buffer_core: vector tables plus a queue scoreboard of expected FIFO contents.
module tb_xadc_sample_buffer_core;
    import xadc_smp_pkg::*;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        smp_valid;
    logic [4:0]  smp_channel;
    logic [15:0] smp_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    bit          m_en, m_ovf;
    logic [4:0]  m_chsel;
    logic [15:0] m_dec, m_dcnt;

    typedef struct {
        logic [4:0]  ch;
        logic [15:0] data;
        int          exp_cnt;
    } vec_t;

    always #5 clk = ~clk;

    xadc_sample_buffer_core dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .read        (read),
        .write       (write),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .smp_valid   (smp_valid),
        .smp_channel (smp_channel),
        .smp_data    (smp_data),
        .irq         (irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        addr = a; cs = 1'b1; read = 1'b1;
        #1;
        v = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        return {16'(exp_q.size()), 13'b0, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
    endfunction

    task automatic check_status(input string name);
        logic [31:0] v;
        rd(5'd0, v);
        check(name, v, exp_status());
    endtask

    task automatic check_head(input string name);
        logic [31:0] v;
        if (exp_q.size() > 0) begin
            rd(5'd1, v);
            check(name, {16'h0, v[15:0]}, {16'h0, exp_q[0]});
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_en = 0; m_ovf = 0; m_chsel = '0; m_dec = '0; m_dcnt = '0;
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = 5'd0; wr_data = d;
        if (d[1]) begin
            exp_q.delete(); m_ovf = 0; m_dcnt = '0;
        end
        if (d[8:4] != m_chsel || d[31:16] != m_dec) m_dcnt = '0;
        m_en = d[0]; m_chsel = d[8:4]; m_dec = d[31:16];
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    // One clock with an optional DRP result and an optional POP write in the same cycle.
    task automatic step(input bit v, input logic [4:0] ch, input logic [15:0] d, input bit pop);
        bit pop_ok, push;
        smp_valid = v; smp_channel = ch; smp_data = d;
        if (pop) begin
            cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'hFFFF_FFFF;
        end
        pop_ok = pop && exp_q.size() > 0;
        push = 0;
        if (v && m_en && ch == m_chsel) begin
            if (m_dcnt == m_dec) begin
                m_dcnt = '0;
                push = 1;
            end else begin
                m_dcnt = m_dcnt + 16'd1;
            end
        end
        if (push && !pop_ok && exp_q.size() == DEPTH) begin
            m_ovf = 1;
            push = 0;
        end
        if (pop_ok) void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
        @(posedge clk); #1;
        smp_valid = 1'b0; cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [15:0] ta, tb_ts, td, te;
        vec_t t1[5];
        vec_t t2[24];

        t1 = '{'{CH_AUX3,   16'h1230, 1},
               '{CH_TEMP,   16'hAAAA, 1},
               '{CH_AUX3,   16'h4560, 2},
               '{CH_VCCINT, 16'hBBBB, 2},
               '{CH_AUX3,   16'h7890, 3}};
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) t2[i] = '{CH_AUX3, 16'((i / 2 + 1) * 16'h0110), (i / 2 + 1) / 4};
            else            t2[i] = '{CH_TEMP, 16'(16'hEE00 + i), ((i + 1) / 2) / 4};
        end

        reset = 1'b1; cs = 0; read = 0; write = 0; addr = '0; wr_data = '0;
        smp_valid = 0; smp_channel = '0; smp_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        rd(5'd0, v); check("reset_status", v, 32'h0000_0001);
        rd(5'd2, v); check("reset_ctrl", v, 32'h0);
        rd(5'd3, v); check("reg3_zero", v, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);

        ctrl_write(32'h0000_0131);
        rd(5'd2, v); check("ctrl_rb", v, 32'h0000_0131);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, t1[i].ch, t1[i].data, 1'b0);
            rd(5'd0, v);
            check($sformatf("t1_cnt%0d", i), {16'h0, v[31:16]}, 32'(t1[i].exp_cnt));
        end
        rd(5'd1, v); check("head_first", {16'h0, v[15:0]}, 32'h1230);
        step(1'b0, '0, '0, 1'b1);
        rd(5'd1, v); check("head_after_pop", {16'h0, v[15:0]}, 32'h4560);
`ifndef XADC_SMP_TSTAMP_EN
        check("head_upper_zero", {16'h0, v[31:16]}, 32'h0);
`endif
        while (exp_q.size() > 0) begin
            check_head("sb_drain1");
            step(1'b0, '0, '0, 1'b1);
        end
        check_status("drained1");

        ctrl_write(32'h0003_0131);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, t2[i].ch, t2[i].data, 1'b0);
            rd(5'd0, v);
            check($sformatf("t2_cnt%0d", i), {16'h0, v[31:16]}, 32'(t2[i].exp_cnt));
        end
        rd(5'd1, v); check("dec_head4", {16'h0, v[15:0]}, 32'h0440);
        while (exp_q.size() > 0) begin
            check_head("sb_dec");
            step(1'b0, '0, '0, 1'b1);
        end

        ctrl_write(32'h0000_0131);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, CH_AUX3, 16'(i), 1'b0);
            if (i == 254) check("irq_below_half", {31'h0, irq}, 32'h0);
            if (i == 255) check("irq_at_half", {31'h0, irq}, 32'h1);
        end
        check_status("full_512");
        step(1'b1, CH_AUX3, 16'hDEAD, 1'b0);
        rd(5'd0, v); check("overflow_status", v, 32'h0200_0006);
        check_status("overflow_model");
        rd(5'd1, v); check("overflow_head", {16'h0, v[15:0]}, 32'h0);

        ctrl_write(32'h0000_0133);
        rd(5'd0, v); check("clear_status", v, 32'h0000_0001);
        rd(5'd2, v); check("clear_ctrl_kept", v, 32'h0000_0131);
        for (int i = 0; i < DEPTH; i++) step(1'b1, CH_AUX3, 16'(i), 1'b0);
        step(1'b1, CH_AUX3, 16'hBEEF, 1'b1);
        rd(5'd0, v); check("full_push_pop", v, 32'h0200_0002);
        rd(5'd1, v); check("full_push_pop_head", {16'h0, v[15:0]}, 32'h0001);
        check_status("full_push_pop_model");

        ctrl_write(32'h0000_0133);
        step(1'b1, CH_AUX3, 16'h5A5A, 1'b1);
        rd(5'd0, v); check("empty_push_pop", v, 32'h0001_0000);
        rd(5'd1, v); check("empty_push_pop_head", {16'h0, v[15:0]}, 32'h5A5A);
        step(1'b0, '0, '0, 1'b1);
        rd(5'd0, v); check("pop_to_empty", v, 32'h0000_0001);
        step(1'b0, '0, '0, 1'b1);
        rd(5'd0, v); check("pop_when_empty", v, 32'h0000_0001);

        ctrl_write(32'h0000_0130);
        step(1'b1, CH_AUX3, 16'h1111, 1'b0);
        check_status("disabled_no_push");
        check("disabled_irq", {31'h0, irq}, 32'h0);

        ctrl_write(32'h0000_0131);
        for (int i = 0; i < 4; i++) step(1'b1, CH_AUX3, 16'(16'h2000 + i), 1'b0);
        check_status("pre_reset");
        #2 reset = 1'b1;
        #1;
        rd(5'd0, v); check("async_reset_status", v, 32'h0000_0001);
        rd(5'd2, v); check("async_reset_ctrl", v, 32'h0);
        model_reset();
        @(posedge clk); #1 reset = 1'b0;

`ifdef XADC_SMP_TSTAMP_EN
        ctrl_write(32'h0000_0131);
        step(1'b1, CH_AUX3, 16'h0001, 1'b0);
        repeat (9) step(1'b0, '0, '0, 1'b0);
        step(1'b1, CH_AUX3, 16'h0002, 1'b0);
        rd(5'd1, v); ta = v[31:16];
        step(1'b0, '0, '0, 1'b1);
        rd(5'd1, v); tb_ts = v[31:16];
        check("ts_diff10", {16'h0, 16'(tb_ts - ta)}, 32'd10);
        ctrl_write(32'h0000_0133);
        step(1'b1, CH_AUX3, 16'h0003, 1'b0);
        rd(5'd1, v); ta = v[31:16];
        repeat (int'(16'(16'hFFF8 - ta - 16'd1))) step(1'b0, '0, '0, 1'b0);
        step(1'b1, CH_AUX3, 16'h0004, 1'b0);
        repeat (9) step(1'b0, '0, '0, 1'b0);
        step(1'b1, CH_AUX3, 16'h0005, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        rd(5'd1, v); td = v[31:16];
        step(1'b0, '0, '0, 1'b1);
        rd(5'd1, v); te = v[31:16];
        check("ts_before_wrap", {16'h0, td}, 32'h0000_FFF8);
        check("ts_wrap_diff10", {16'h0, 16'(te - td)}, 32'd10);
        check("ts_wrap_value", {16'h0, te}, 32'h0000_0002);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
